// File: rtl/tmds_deserializer_pkg.sv
// Shared TMDS definitions: the four control tokens and the word-alignment state encoding.
// The token matcher and the deserializer both import this package.
package tmds_deserializer_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] TOKEN_CTL0 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] TOKEN_CTL1 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] TOKEN_CTL2 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] TOKEN_CTL3 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

endpackage

// File: rtl/tmds_token_match.sv
// Combinational TMDS control-token detector: flags a 10-bit word that is one of the
// four control tokens and recovers the {c1,c0} control pair it carries.
module tmds_token_match
    import tmds_deserializer_pkg::*;
(
    input  logic [TMDS_W-1:0] word_i,
    output logic              is_token_o,
    output logic [1:0]        ctl_o
);

    always_comb begin
        is_token_o = 1'b1;
        ctl_o      = 2'b00;
        case (word_i)
            TOKEN_CTL0: ctl_o = 2'b00;
            TOKEN_CTL1: ctl_o = 2'b01;
            TOKEN_CTL2: ctl_o = 2'b10;
            TOKEN_CTL3: ctl_o = 2'b11;
            default:    is_token_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_deserializer.sv
// TMDS serial-to-parallel receiver: shifts bits in LSB-first, aligns to control tokens,
// and emits one parallel word per WIDTH clocks once LOCK_COUNT aligned tokens are seen.
module tmds_deserializer
    import tmds_deserializer_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int LOCK_COUNT   = 8,
    parameter int LOSS_TIMEOUT = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             is_token,
    output logic             locked
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int MC_W  = $clog2(LOCK_COUNT + 1);
    localparam int TC_W  = $clog2(LOSS_TIMEOUT + 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d, mcnt_inc;
    logic [TC_W-1:0]  tcnt_q, tcnt_d, tcnt_inc;
    align_state_t     state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             tok_q, tok_d;
    logic             locked_q, locked_d;
    logic             match;
    logic [1:0]       ctl_unused;
    logic             boundary;
    logic             emit;

    tmds_token_match u_match (
        .word_i     (sr_q),
        .is_token_o (match),
        .ctl_o      (ctl_unused)
    );

    assign boundary = (cnt_q == '0);
    assign mcnt_inc = mcnt_q + 1'b1;
    assign tcnt_inc = tcnt_q + 1'b1;

    always_comb begin
        sr_d     = {serial_in, sr_q[WIDTH-1:1]};
        cnt_d    = (cnt_q == CNT_W'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
        mcnt_d   = mcnt_q;
        tcnt_d   = tcnt_q;
        state_d  = state_q;
        dout_d   = dout_q;
        tok_d    = tok_q;
        dv_d     = 1'b0;
        emit     = 1'b0;
        case (state_q)
            SEARCH: begin
                // Any token found mid-stream re-phases the bit counter onto it.
                if (match) begin
                    cnt_d   = CNT_W'(1);
                    mcnt_d  = MC_W'(1);
                    state_d = CONFIRM;
                end
            end
            CONFIRM: begin
                if (boundary) begin
                    if (match) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == MC_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            tcnt_d  = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        mcnt_d  = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (match) begin
                        tcnt_d = '0;
                    end else begin
                        tcnt_d = tcnt_inc;
                        // The word that exhausts the timeout is dropped with the lock.
                        if (tcnt_inc == TC_W'(LOSS_TIMEOUT)) begin
                            state_d = SEARCH;
                            mcnt_d  = '0;
                            emit    = 1'b0;
                        end
                    end
                end
                if (emit) begin
                    dout_d = sr_q;
                    tok_d  = match;
                    dv_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            mcnt_q   <= '0;
            tcnt_q   <= '0;
            state_q  <= SEARCH;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            tok_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
            tcnt_q   <= tcnt_d;
            state_q  <= state_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            tok_q    <= tok_d;
            locked_q <= locked_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign is_token   = tok_q;
    assign locked     = locked_q;

endmodule
